// File: rtl/mem_byte_access_unit.sv
// Memory-stage byte sequencer: a 16-bit big-endian load/store becomes a HI then a LO byte cycle.
// Optional feature macro: ACCESS_CHECK_EN (reject odd or out-of-range addresses via rsp_err_o).
module mem_byte_access_unit #(
   parameter int unsigned MEM_BYTES = 100,
   parameter int unsigned BYTE_WAIT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   input  logic        req_write_i,
   input  logic [15:0] req_addr_i,
   input  logic [15:0] req_wdata_i,
   output logic        ready_o,
   output logic        busy_o,
   output logic        rsp_valid_o,
   output logic [15:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic [15:0] mem_addr_o,
   output logic [7:0]  mem_wdata_o,
   output logic        mem_we_o,
   input  logic [7:0]  mem_rdata_i
);

   typedef enum logic [1:0] {IDLE, HI, LO, RESP} state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(BYTE_WAIT);

   if (BYTE_WAIT > 15) begin : g_bad_byte_wait
      $error("BYTE_WAIT must be in 0..15");
   end
   if (MEM_BYTES < 2 || MEM_BYTES > 65536) begin : g_bad_mem_bytes
      $error("MEM_BYTES must be in 2..65536");
   end

   state_t      state_q, state_d;
   logic [3:0]  wcnt_q, wcnt_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        write_q, write_d;
   logic [7:0]  rhi_q, rhi_d;
   logic [15:0] rdata_q, rdata_d;
   logic        accept;

`ifdef ACCESS_CHECK_EN
   logic        err_q, err_d;
   logic [16:0] addr_end;
   logic        req_err;

   // 17-bit sum so that addr 0xFFFF cannot wrap below the limit
   assign addr_end  = {1'b0, req_addr_i} + 17'd1;
   assign req_err   = req_addr_i[0] | (addr_end >= 17'(MEM_BYTES));
   assign rsp_err_o = err_q;
`else
   assign rsp_err_o = 1'b0;
`endif

   assign ready_o     = (state_q == IDLE) | (state_q == RESP);
   assign busy_o      = (state_q == HI) | (state_q == LO);
   assign rsp_valid_o = (state_q == RESP);
   assign rsp_rdata_o = rdata_q;
   assign accept      = ready_o & req_valid_i;

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      write_d = write_q;
      rhi_d   = rhi_q;
      rdata_d = rdata_q;
`ifdef ACCESS_CHECK_EN
      err_d   = err_q;
`endif
      case (state_q)
         HI: begin
            if (wcnt_q != 4'd0) begin
               wcnt_d = wcnt_q - 4'd1;
            end else begin
               if (!write_q) rhi_d = mem_rdata_i;
               wcnt_d  = WAIT_LOAD;
               state_d = LO;
            end
         end
         LO: begin
            if (wcnt_q != 4'd0) begin
               wcnt_d = wcnt_q - 4'd1;
            end else begin
               // response data is only updated here, so it holds until the next response
               rdata_d = write_q ? 16'h0000 : {rhi_q, mem_rdata_i};
`ifdef ACCESS_CHECK_EN
               err_d   = 1'b0;
`endif
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = state_q;
      endcase

      if (accept) begin
         addr_d  = req_addr_i;
         wdata_d = req_wdata_i;
         write_d = req_write_i;
         wcnt_d  = WAIT_LOAD;
         state_d = HI;
`ifdef ACCESS_CHECK_EN
         if (req_err) begin
            err_d   = 1'b1;
            rdata_d = 16'h0000;
            state_d = RESP;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         wcnt_q  <= 4'd0;
         addr_q  <= 16'h0000;
         wdata_q <= 16'h0000;
         write_q <= 1'b0;
         rhi_q   <= 8'h00;
         rdata_q <= 16'h0000;
`ifdef ACCESS_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
         rhi_q   <= rhi_d;
         rdata_q <= rdata_d;
`ifdef ACCESS_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

   // Memory strobes decode from state only, so an async reset drops mem_we_o at once
   always_comb begin
      mem_addr_o  = 16'h0000;
      mem_wdata_o = 8'h00;
      mem_we_o    = 1'b0;
      case (state_q)
         HI: begin
            mem_addr_o  = addr_q;
            mem_wdata_o = write_q ? wdata_q[15:8] : 8'h00;
            mem_we_o    = write_q;
         end
         LO: begin
            mem_addr_o  = addr_q + 16'd1;
            mem_wdata_o = write_q ? wdata_q[7:0] : 8'h00;
            mem_we_o    = write_q;
         end
         default: begin
            mem_addr_o  = 16'h0000;
            mem_wdata_o = 8'h00;
            mem_we_o    = 1'b0;
         end
      endcase
   end

endmodule
